tdc_histogrammer: RTL and testbench

- Consumes the TDC event outputs (start/end channel codes, 7-bit interval, data_arrived strobe) and builds a signed-delay coincidence histogram in on-chip RAM.
- Bin address = {direction, interval}. Bins 0..127 hold pulse1→pulse2 delays and zero-delay coincidences; bins 128..255 hold pulse2→pulse1 delays.
- Sits directly downstream of the TDC. A host-side readout controller reads results out.

---
 rtl/tdc_histogrammer.sv | 207 ++++++++++++++++++++
 tb/tb_tdc_histogrammer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_histogrammer.sv
// tdc_histogrammer
//   Builds a signed-delay coincidence histogram from TDC events in on-chip RAM.
//   Bin address = {direction, interval}: bins 0..2^IV_W-1 hold pulse1->pulse2
//   delays (bin 0 also takes zero-delay coincidences), the upper half holds
//   pulse2->pulse1 delays. Events go through a fixed read-modify-write pipeline
//   with forwarding, so back-to-back hits on one bin each count.
//
//   Optional feature macro: TDC_HIST_OVF_STOP_EN
//     defined   : a saturating bin write ends acquisition (ACQ->DRAIN->IDLE);
//                 re-arming needs acq_en to go low, then high again.
//     undefined : ovf is only a sticky flag; acquisition continues.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start_signal, end_signal TDC channel codes (earlier / later pulse)
//   interval                 TDC interval in clk cycles
//   data_arrived             TDC event strobe (level, high >= 2 cycles)
//   acq_en                   level, accumulate events while high
//   clear_req                pulse, zero all bins and counters (IDLE only)
//   rd_req, rd_addr          bin read request (IDLE only, pipelined)
//   rd_valid, rd_data        read response, 2 cycles after rd_req
//   busy                     CLEAR or ACQ, or events still in flight
//   ovf                      sticky, some bin reached its maximum
//   total_events             accepted events, saturating
//   dropped_events           rejected channel codes, saturating
module tdc_histogrammer #(
  parameter int IV_W  = 7,
  parameter int CNT_W = 16,
  parameter int TOT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        start_signal,
  input  logic [1:0]        end_signal,
  input  logic [IV_W-1:0]   interval,
  input  logic              data_arrived,
  input  logic              acq_en,
  input  logic              clear_req,
  input  logic              rd_req,
  input  logic [IV_W:0]     rd_addr,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              busy,
  output logic              ovf,
  output logic [TOT_W-1:0]  total_events,
  output logic [TOT_W-1:0]  dropped_events
);

  localparam int AW    = IV_W + 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACQ, S_DRAIN} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] ram_q;
  logic [AW-1:0]    ram_addr;

  logic             s1, s2, s3, rise;
  logic             p1_v;
  logic [1:0]       p1_start, p1_end;
  logic [IV_W-1:0]  p1_iv;
  logic             cls_ok;
  logic [AW-1:0]    cls_addr;
  logic             p2_v;
  logic [AW-1:0]    p2_addr;
  logic [CNT_W-1:0] base, incr;
  logic             p3_v, p3_sat;
  logic [AW-1:0]    p3_addr;
  logic [CNT_W-1:0] p3_val;
  logic             p4_v;
  logic [AW-1:0]    p4_addr;
  logic [CNT_W-1:0] p4_val;
  logic [AW-1:0]    clr_addr;
  logic             rd_p1;
  logic             acq_ok, stop_now;

  assign rise = s2 & ~s3;

`ifdef TDC_HIST_OVF_STOP_EN
  logic stop_hold;
  assign stop_now = p3_v & p3_sat;
  assign acq_ok   = acq_en & ~stop_hold;

  always_ff @(posedge clk) begin
    if (rst)           stop_hold <= 1'b0;
    else if (stop_now) stop_hold <= 1'b1;
    else if (!acq_en)  stop_hold <= 1'b0;
  end
`else
  assign stop_now = 1'b0;
  assign acq_ok   = acq_en;
`endif

  always_comb begin
    cls_ok   = 1'b0;
    cls_addr = '0;
    case ({p1_start, p1_end})
      4'b0011: cls_ok = 1'b1;
      4'b1001: begin cls_ok = 1'b1; cls_addr = {1'b0, p1_iv}; end
      4'b0110: begin cls_ok = 1'b1; cls_addr = {1'b1, p1_iv}; end
      default: cls_ok = 1'b0;
    endcase
  end

  // Pipeline events and host reads never overlap (reads only in IDLE,
  // pipeline only live in ACQ/DRAIN), so they share one RAM read port.
  assign ram_addr = p1_v ? cls_addr : rd_addr;

  // p3 is the write being issued now; p4 was written on the same edge that
  // the E2 event's RAM read sampled, so both are newer than ram_q.
  always_comb begin
    if (p3_v && p3_addr == p2_addr)      base = p3_val;
    else if (p4_v && p4_addr == p2_addr) base = p4_val;
    else                                 base = ram_q;
    incr = (base == '1) ? base : base + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (state == S_CLEAR) mem[clr_addr] <= '0;
    else if (p3_v)        mem[p3_addr]  <= p3_val;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_CLEAR: if (clr_addr == '1) state_nx = S_IDLE;
      S_IDLE: begin
        if (clear_req)   state_nx = S_CLEAR;
        else if (acq_ok) state_nx = S_ACQ;
      end
      S_ACQ:   if (!acq_en || stop_now) state_nx = S_DRAIN;
      S_DRAIN: if (!p1_v && !p2_v && !p3_v) state_nx = S_IDLE;
      default: state_nx = S_CLEAR;
    endcase
  end

  assign busy = (state == S_CLEAR) || (state == S_ACQ) || p1_v || p2_v || p3_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_CLEAR;
      clr_addr       <= '0;
      s1             <= 1'b0;
      s2             <= 1'b0;
      s3             <= 1'b0;
      p1_v           <= 1'b0;
      p1_start       <= '0;
      p1_end         <= '0;
      p1_iv          <= '0;
      p2_v           <= 1'b0;
      p2_addr        <= '0;
      p3_v           <= 1'b0;
      p3_sat         <= 1'b0;
      p3_addr        <= '0;
      p3_val         <= '0;
      p4_v           <= 1'b0;
      p4_addr        <= '0;
      p4_val         <= '0;
      rd_p1          <= 1'b0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      ovf            <= 1'b0;
      total_events   <= '0;
      dropped_events <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= (state == S_CLEAR) ? clr_addr + AW'(1) : '0;
      s1       <= data_arrived;
      s2       <= s1;
      s3       <= s2;

      p1_v <= rise && (state == S_ACQ);
      if (rise) begin
        p1_start <= start_signal;
        p1_end   <= end_signal;
        p1_iv    <= interval;
      end
      p2_v    <= p1_v & cls_ok;
      p2_addr <= cls_addr;
      p3_v    <= p2_v;
      p3_addr <= p2_addr;
      p3_val  <= incr;
      p3_sat  <= p2_v && (incr == '1);
      p4_v    <= p3_v;
      p4_addr <= p3_addr;
      p4_val  <= p3_val;

      rd_p1    <= rd_req && (state == S_IDLE);
      rd_valid <= rd_p1;
      if (rd_p1) rd_data <= ram_q;

      if (state == S_CLEAR && clr_addr == '1) begin
        total_events   <= '0;
        dropped_events <= '0;
        ovf            <= 1'b0;
      end else begin
        if (p3_v && total_events != '1) total_events <= total_events + TOT_W'(1);
        if (p1_v && !cls_ok && dropped_events != '1)
          dropped_events <= dropped_events + TOT_W'(1);
        if (p3_v && p3_sat) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tdc_histogrammer.sv
// tb_tdc_histogrammer
//   Scoreboard bench for tdc_histogrammer (built with CNT_W=4 so bin
//   saturation is reachable). A histogram model keeps expected bin counts
//   and totals; reads push expected data into a queue that a negedge
//   monitor pops when rd_valid appears.
module tb_tdc_histogrammer;
  localparam int IV_W  = 7;
  localparam int CNT_W = 4;
  localparam int TOT_W = 32;
  localparam int NB    = 256;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       start_signal = '0;
  logic [1:0]       end_signal = '0;
  logic [IV_W-1:0]  interval = '0;
  logic             data_arrived = 1'b0;
  logic             acq_en = 1'b0;
  logic             clear_req = 1'b0;
  logic             rd_req = 1'b0;
  logic [IV_W:0]    rd_addr = '0;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic             busy;
  logic             ovf;
  logic [TOT_W-1:0] total_events;
  logic [TOT_W-1:0] dropped_events;

  always #5 clk = ~clk;

  tdc_histogrammer #(.IV_W(IV_W), .CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
    .clk(clk), .rst(rst), .start_signal(start_signal), .end_signal(end_signal),
    .interval(interval), .data_arrived(data_arrived), .acq_en(acq_en),
    .clear_req(clear_req), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .ovf(ovf),
    .total_events(total_events), .dropped_events(dropped_events)
  );

  int total_chk = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // histogram model
  int     m_bin [NB];
  longint m_tot, m_drop;
  bit     m_ovf, m_acq, m_stopped;

  typedef struct { int addr; int exp; int due; } rd_t;
  rd_t rq[$];
  rd_t mon_r;

  task automatic check(input string name, input longint act, input longint exp);
    total_chk++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      if (rq.size() == 0) begin
        total_chk++;
        bad++;
        $display("FAIL rd_unexpected: got rd_valid=1 data=%0d expected no response", rd_data);
      end else begin
        mon_r = rq.pop_front();
        check($sformatf("rd_data[%0d]", mon_r.addr), longint'(rd_data), mon_r.exp);
        check($sformatf("rd_latency[%0d]", mon_r.addr), cyc, mon_r.due);
      end
    end
  end

  function automatic void model_clear();
    foreach (m_bin[i]) m_bin[i] = 0;
    m_tot = 0;
    m_drop = 0;
    m_ovf = 0;
    m_stopped = 0;
  endfunction

  function automatic void model_event(input int s, input int e, input int iv);
    int a;
    if (!m_acq || m_stopped) return;
    if (s == 0 && e == 3)      a = 0;
    else if (s == 2 && e == 1) a = iv;
    else if (s == 1 && e == 2) a = 128 + iv;
    else begin
      m_drop++;
      return;
    end
    if (m_bin[a] < MAXC) m_bin[a]++;
    m_tot++;
    if (m_bin[a] == MAXC) begin
      m_ovf = 1;
`ifdef TDC_HIST_OVF_STOP_EN
      m_stopped = 1;
`endif
    end
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a);
    rd_req = 1'b1;
    rd_addr = a[IV_W:0];
    rq.push_back('{a, m_bin[a], cyc + 2});
    tick();
    rd_req = 1'b0;
  endtask

  task automatic rd_flush(input string name);
    tick(4);
    check(name, rq.size(), 0);
    rq.delete();
  endtask

  task automatic ev(input int s, input int e, input int iv, input int lo = 3);
    start_signal = s[1:0];
    end_signal = e[1:0];
    interval = iv[IV_W-1:0];
    data_arrived = 1'b1;
    tick(2);
    data_arrived = 1'b0;
    tick(lo);
    model_event(s, e, iv);
  endtask

  task automatic acq_on();
    acq_en = 1'b1;
    tick(3);
    m_acq = 1;
    m_stopped = 0;
  endtask

  task automatic acq_off(input string name);
    int n = 0;
    acq_en = 1'b0;
    m_acq = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check(name, busy, 0);
    tick(2);
  endtask

  task automatic count_clear(input string name);
    int n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    check(name, n, 256);
  endtask

  task automatic check_totals(input string tag);
    check({tag, "_total"}, total_events, m_tot);
    check({tag, "_dropped"}, dropped_events, m_drop);
    check({tag, "_ovf"}, ovf, m_ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int s, e, iv, r;
    model_clear();
    m_acq = 0;

    // reset state
    tick(3);
    check("rst_busy", busy, 1);
    check("rst_rd_valid", rd_valid, 0);
    check_totals("rst");
    rst = 1'b0;
    count_clear("reset_clear_cycles");
    check_totals("post_clear");
    for (int a = 0; a < NB; a++) rd(a);
    rd_flush("rd_all_zero_flush");

    // directed events, plus clear/read requests that ACQ must ignore
    ev(2, 1, 10);                       // stray event while idle: ignored
    acq_on();
    ev(2, 1, 10);
    ev(1, 2, 5);
    ev(0, 3, 77);
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    rd_req = 1'b1; rd_addr = 8'd10; tick(); rd_req = 1'b0;
    // two events to bin 42 with edges two cycles apart
    start_signal = 2'b10; end_signal = 2'b01; interval = 7'd42;
    data_arrived = 1'b1; tick(); data_arrived = 1'b0; tick();
    data_arrived = 1'b1; tick(); data_arrived = 1'b0; tick(4);
    model_event(2, 1, 42);
    model_event(2, 1, 42);
    ev(2, 2, 9);
    ev(1, 2, 0);                        // interval 0 in reverse direction
    ev(3, 0, 4);
    acq_off("drain1");
    check_totals("dir");
    rd(10); rd(138); rd(133); rd(0); rd(42); rd(9); rd(128); rd(137);
    rd_flush("rd_dir_flush");

    // randomized session
    acq_on();
    repeat (80) begin
      r = $urandom_range(0, 9);
      if (r < 4)       begin s = 2; e = 1; end
      else if (r < 8)  begin s = 1; e = 2; end
      else if (r == 8) begin s = 0; e = 3; end
      else begin s = $urandom_range(0, 3); e = $urandom_range(0, 3); end
      iv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 5);
      ev(s, e, iv, $urandom_range(2, 5));
    end
    acq_off("drain_rand");
    check_totals("rand");
    for (int a = 0; a < NB; a++) rd(a);
    rd_flush("rd_rand_flush");

    // host clear from IDLE
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    model_clear();
    count_clear("req_clear_cycles");
    check_totals("req_clear");
    for (int a = 0; a < NB; a++) rd(a);
    rd_flush("rd_clear_flush");

    // saturation: 16 events to bin 7
    acq_on();
    repeat (16) ev(2, 1, 7);
    tick(2);
    check("sat_busy", busy, m_stopped ? 0 : 1);
    check_totals("sat");
    acq_off("drain_sat");
    rd(7); rd(135);
    rd_flush("rd_sat_flush");

    // reset during acquisition
    acq_on();
    ev(1, 2, 20);
    ev(2, 1, 20);
    start_signal = 2'b10; end_signal = 2'b01; interval = 7'd20;
    data_arrived = 1'b1;
    tick(2);
    rst = 1'b1;
    acq_en = 1'b0;
    data_arrived = 1'b0;
    tick(2);
    m_acq = 0;
    model_clear();
    rst = 1'b0;
    count_clear("rst_acq_clear_cycles");
    check_totals("rst_acq");
    rd(7); rd(20); rd(148); rd(0);
    rd_flush("rd_rst_flush");

    $display("test done: total=%0d bad=%0d", total_chk, bad);
    $finish;
  end
endmodule
